seq_alu: RTL

- Parametrised, pipelined successor of the execute-stage ALU, with valid/ready handshakes on both input and output.
- Single-cycle ops: add, sub, mul, and, or. Each completes in one registered cycle.
- div and mod use an iterative restoring divider, one quotient bit per cycle, so no combinational divider sits in the critical path.
- Flags: Z/N/V/C, plus a dedicated divide-by-zero flag.

---
 rtl/seq_alu_if.sv | 29 ++
 rtl/seq_alu.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu_if.sv
// Handshake bus for seq_alu: operand/opcode request channel and result/flag response channel.
interface seq_alu_if #(
   parameter int unsigned WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] reg1;
   logic [WIDTH-1:0] reg2;
   logic [3:0]       operation;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             z_flag;
   logic             n_flag;
   logic             v_flag;
   logic             c_flag;
   logic             dz_flag;
   logic             busy;

   modport master (
      output in_valid, reg1, reg2, operation, out_ready,
      input  in_ready, out_valid, result, z_flag, n_flag, v_flag, c_flag, dz_flag, busy
   );

   modport slave (
      input  in_valid, reg1, reg2, operation, out_ready,
      output in_ready, out_valid, result, z_flag, n_flag, v_flag, c_flag, dz_flag, busy
   );
endinterface

// File: rtl/seq_alu.sv
// Pipelined execute-stage ALU: single-cycle arithmetic/logic ops plus an
// iterative restoring divider (one quotient bit per cycle) for div/mod.
module seq_alu #(
   parameter int unsigned WIDTH = 32
) (
   input  logic     clk,
   input  logic     rst,
   seq_alu_if.slave bus
);
   localparam int unsigned CNT_W = $clog2(WIDTH + 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_DIV  = 2'd1;
   localparam logic [1:0] S_FIX  = 2'd2;

   localparam logic [3:0] OP_ADD = 4'b0000;
   localparam logic [3:0] OP_SUB = 4'b0001;
   localparam logic [3:0] OP_MUL = 4'b0010;
   localparam logic [3:0] OP_DIV = 4'b0011;
   localparam logic [3:0] OP_MOD = 4'b0100;
   localparam logic [3:0] OP_AND = 4'b1000;
   localparam logic [3:0] OP_OR  = 4'b1001;

   localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] dvd_q, dvd_d;     // dividend magnitude, shifts into quotient
   logic [WIDTH-1:0] dvs_q, dvs_d;     // divisor magnitude
   logic [WIDTH-1:0] rem_q, rem_d;     // partial remainder
   logic             qneg_q, qneg_d;
   logic             rneg_q, rneg_d;
   logic             mod_q, mod_d;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             z_q, z_d, n_q, n_d, v_q, v_d, c_q, c_d, dz_q, dz_d;

   logic             in_ready_c;
   logic             accept_c;
   logic [WIDTH-1:0] a_c, b_c;
   logic [WIDTH:0]   sum_c, diff_c;
   logic [2*WIDTH-1:0] prod_c;
   logic [WIDTH-1:0] a_abs_c, b_abs_c;
   logic [WIDTH:0]   rem_sh_c, trial_c;
   logic [WIDTH-1:0] quo_c, rmd_c;
   logic             ld_c, ld_v_c, ld_cy_c, ld_dz_c;
   logic [WIDTH-1:0] ld_res_c;

   assign a_c        = bus.reg1;
   assign b_c        = bus.reg2;
   assign in_ready_c = !rst && (state_q == S_IDLE) && (!out_valid_q || bus.out_ready);
   assign accept_c   = bus.in_valid && in_ready_c;

   assign bus.in_ready  = in_ready_c;
   assign bus.out_valid = out_valid_q;
   assign bus.result    = result_q;
   assign bus.z_flag    = z_q;
   assign bus.n_flag    = n_q;
   assign bus.v_flag    = v_q;
   assign bus.c_flag    = c_q;
   assign bus.dz_flag   = dz_q;
   assign bus.busy      = (state_q != S_IDLE);

   // Next-state, divider step and output-register load selection
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      dvd_d       = dvd_q;
      dvs_d       = dvs_q;
      rem_d       = rem_q;
      qneg_d      = qneg_q;
      rneg_d      = rneg_q;
      mod_d       = mod_q;
      out_valid_d = out_valid_q && !bus.out_ready;
      result_d    = result_q;
      z_d         = z_q;
      n_d         = n_q;
      v_d         = v_q;
      c_d         = c_q;
      dz_d        = dz_q;
      ld_c        = 1'b0;
      ld_res_c    = '0;
      ld_v_c      = 1'b0;
      ld_cy_c     = 1'b0;
      ld_dz_c     = 1'b0;

      sum_c    = {1'b0, a_c} + {1'b0, b_c};
      diff_c   = {1'b0, a_c} - {1'b0, b_c};
      prod_c   = $signed({{WIDTH{a_c[WIDTH-1]}}, a_c}) * $signed({{WIDTH{b_c[WIDTH-1]}}, b_c});
      a_abs_c  = a_c[WIDTH-1] ? (WIDTH'(0) - a_c) : a_c;
      b_abs_c  = b_c[WIDTH-1] ? (WIDTH'(0) - b_c) : b_c;
      rem_sh_c = {rem_q, dvd_q[WIDTH-1]};
      trial_c  = rem_sh_c - {1'b0, dvs_q};
      quo_c    = qneg_q ? (WIDTH'(0) - dvd_q) : dvd_q;
      rmd_c    = rneg_q ? (WIDTH'(0) - rem_q) : rem_q;

      case (state_q)
         S_IDLE: begin
            if (accept_c) begin
               ld_c = 1'b1;
               case (bus.operation)
                  OP_ADD: begin
                     ld_res_c = sum_c[WIDTH-1:0];
                     ld_cy_c  = sum_c[WIDTH];
                     ld_v_c   = (a_c[WIDTH-1] == b_c[WIDTH-1]) && (sum_c[WIDTH-1] != a_c[WIDTH-1]);
                  end
                  OP_SUB: begin
                     ld_res_c = diff_c[WIDTH-1:0];
                     ld_cy_c  = diff_c[WIDTH];
                     ld_v_c   = (a_c[WIDTH-1] != b_c[WIDTH-1]) && (diff_c[WIDTH-1] != a_c[WIDTH-1]);
                  end
                  OP_MUL: begin
                     ld_res_c = prod_c[WIDTH-1:0];
                     ld_v_c   = (prod_c[2*WIDTH-1:WIDTH] != {WIDTH{prod_c[WIDTH-1]}});
                  end
                  OP_DIV, OP_MOD: begin
                     if (b_c == '0) begin
                        ld_dz_c = 1'b1;
                     end else if ((a_c == MIN_VAL) && (b_c == '1)) begin
                        ld_res_c = (bus.operation == OP_DIV) ? MIN_VAL : '0;
                        ld_v_c   = (bus.operation == OP_DIV);
                     end else begin
                        ld_c    = 1'b0;
                        dvd_d   = a_abs_c;
                        dvs_d   = b_abs_c;
                        rem_d   = '0;
                        cnt_d   = CNT_W'(WIDTH - 1);
                        qneg_d  = a_c[WIDTH-1] ^ b_c[WIDTH-1];
                        rneg_d  = a_c[WIDTH-1];
                        mod_d   = (bus.operation == OP_MOD);
                        state_d = S_DIV;
                     end
                  end
                  OP_AND:  ld_res_c = a_c & b_c;
                  OP_OR:   ld_res_c = a_c | b_c;
                  default: ld_res_c = '0;
               endcase
            end
         end
         S_DIV: begin
            // restoring step: keep the trial subtraction only if it did not borrow
            if (!trial_c[WIDTH]) begin
               rem_d = trial_c[WIDTH-1:0];
               dvd_d = {dvd_q[WIDTH-2:0], 1'b1};
            end else begin
               rem_d = rem_sh_c[WIDTH-1:0];
               dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
            end
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == '0) begin
               state_d = S_FIX;
            end
         end
         S_FIX: begin
            ld_c     = 1'b1;
            ld_res_c = mod_q ? rmd_c : quo_c;
            state_d  = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if (ld_c) begin
         out_valid_d = 1'b1;
         result_d    = ld_res_c;
         z_d         = (ld_res_c == '0);
         n_d         = ld_res_c[WIDTH-1];
         v_d         = ld_v_c;
         c_d         = ld_cy_c;
         dz_d        = ld_dz_c;
      end
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         dvd_q       <= '0;
         dvs_q       <= '0;
         rem_q       <= '0;
         qneg_q      <= 1'b0;
         rneg_q      <= 1'b0;
         mod_q       <= 1'b0;
         out_valid_q <= 1'b0;
         result_q    <= '0;
         z_q         <= 1'b0;
         n_q         <= 1'b0;
         v_q         <= 1'b0;
         c_q         <= 1'b0;
         dz_q        <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         dvd_q       <= dvd_d;
         dvs_q       <= dvs_d;
         rem_q       <= rem_d;
         qneg_q      <= qneg_d;
         rneg_q      <= rneg_d;
         mod_q       <= mod_d;
         out_valid_q <= out_valid_d;
         result_q    <= result_d;
         z_q         <= z_d;
         n_q         <= n_d;
         v_q         <= v_d;
         c_q         <= c_d;
         dz_q        <= dz_d;
      end
   end
endmodule
